// File: rtl/arb_nxm.sv
// arb_nxm: NUM_M-master to NUM_S-slave bus arbiter with address decode and slave timeout.
// One transaction in flight at a time, walking IDLE -> XFER -> RESP -> IDLE.
module arb_nxm #(
    parameter int NUM_M   = 4,
    parameter int NUM_S   = 4,
    parameter int DATA_W  = 32,
    parameter int RR      = 1,
    parameter int TIMEOUT = 900
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_M-1:0]        m_req,
    input  logic [NUM_M*32-1:0]     m_addr,
    input  logic [NUM_M-1:0]        m_we,
    input  logic [NUM_M*DATA_W-1:0] m_wdata,
    output logic [NUM_M-1:0]        m_gnt,
    output logic [NUM_M-1:0]        m_ack,
    output logic                    m_err,
    output logic [DATA_W-1:0]       m_rdata,
    output logic [NUM_S-1:0]        s_sel,
    output logic [31:0]             s_addr,
    output logic                    s_we,
    output logic [DATA_W-1:0]       s_wdata,
    input  logic [NUM_S-1:0]        s_ack,
    input  logic [NUM_S*DATA_W-1:0] s_rdata
);

    localparam int         MW     = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int         CW     = $clog2(TIMEOUT + 1);
    localparam logic [4:0] NUM_S5 = 5'(NUM_S);

    typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;
    state_t state, state_nx;

    logic [MW-1:0]     last, win_idx;
    logic              win_any;
    logic [NUM_M-1:0]  rot;
    int                base, pick;

    logic [31:0]       addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic              err_q;
    logic [CW-1:0]     cnt;

    logic              hit, sack, tmo, xfer_hit;
    logic [3:0]        sidx;
    logic [NUM_S-1:0]  sel;
    logic [DATA_W-1:0] srd;

    // Rotate requests so the search begins just after the last winner (or at 0 in fixed mode).
    always_comb begin
        base    = 0;
        pick    = 0;
        win_any = 1'b0;
        if (RR != 0) begin
            base = int'(last) + 1;
            if (base >= NUM_M) base = 0;
        end
        rot = NUM_M'({m_req, m_req} >> base);
        for (int i = NUM_M - 1; i >= 0; i--) begin
            if (rot[i]) begin
                win_any = 1'b1;
                pick    = base + i;
            end
        end
        if (pick >= NUM_M) pick = pick - NUM_M;
        win_idx = MW'(pick);
    end

    assign sidx     = addr_q[15:12];
    assign hit      = (addr_q[31:16] == 16'hFFEF) && (addr_q[11:8] == 4'h2) && ({1'b0, sidx} < NUM_S5);
    assign tmo      = (cnt == CW'(TIMEOUT - 1));
    assign xfer_hit = (state == XFER) && hit;

    always_comb begin
        sel  = '0;
        sack = 1'b0;
        srd  = '0;
        for (int j = 0; j < NUM_S; j++) begin
            if (hit && sidx == 4'(j)) begin
                sel[j] = 1'b1;
                sack   = s_ack[j];
                srd    = s_rdata[j*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (win_any) state_nx = XFER;
            XFER:    if (!hit || sack || tmo) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The winner's request is latched at grant so a master may drop m_req without disturbing the transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            m_gnt   <= '0;
            last    <= MW'(NUM_M - 1);
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt     <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (win_any) begin
                        last    <= win_idx;
                        cnt     <= '0;
                        err_q   <= 1'b0;
                        rdata_q <= '0;
                        for (int i = 0; i < NUM_M; i++) begin
                            m_gnt[i] <= (win_idx == MW'(i));
                            if (win_idx == MW'(i)) begin
                                addr_q  <= m_addr[32*i +: 32];
                                we_q    <= m_we[i];
                                wdata_q <= m_wdata[i*DATA_W +: DATA_W];
                            end
                        end
                    end
                end
                XFER: begin
                    cnt <= cnt + 1'b1;
                    if (!hit) begin
                        err_q <= 1'b1;
                    end else if (sack) begin
                        if (!we_q) rdata_q <= srd;
                    end else if (tmo) begin
                        err_q <= 1'b1;
                    end
                end
                RESP:    m_gnt <= '0;
                default: m_gnt <= '0;
            endcase
        end
    end

    always_comb begin
        m_ack   = '0;
        m_err   = 1'b0;
        m_rdata = '0;
        if (state == RESP) begin
            m_ack = m_gnt;
            m_err = err_q;
            if (!err_q) m_rdata = rdata_q;
        end
    end

    assign s_sel   = xfer_hit ? sel     : '0;
    assign s_addr  = xfer_hit ? addr_q  : '0;
    assign s_we    = xfer_hit & we_q;
    assign s_wdata = xfer_hit ? wdata_q : '0;

endmodule

// File: tb/tb_arb_nxm.sv
// tb_arb_nxm: randomized and directed transactions against a transaction-level model of arb_nxm.
// A second instance in fixed-priority mode has its slaves acking in the first transfer cycle.
module tb_arb_nxm;

    localparam int NM = 4;
    localparam int NS = 4;
    localparam int DW = 32;
    localparam int TO = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [NM-1:0]    m_req;
    logic [NM*32-1:0] m_addr;
    logic [NM-1:0]    m_we;
    logic [NM*DW-1:0] m_wdata;
    logic [NM-1:0]    m_gnt, m_ack;
    logic             m_err;
    logic [DW-1:0]    m_rdata;
    logic [NS-1:0]    s_sel;
    logic [31:0]      s_addr;
    logic             s_we;
    logic [DW-1:0]    s_wdata;
    logic [NS-1:0]    s_ack;
    logic [NS*DW-1:0] s_rdata;

    logic [NM-1:0]    m_req_f;
    logic [NM*32-1:0] m_addr_f;
    logic [NM-1:0]    m_we_f;
    logic [NM*DW-1:0] m_wdata_f;
    logic [NM-1:0]    m_gnt_f, m_ack_f;
    logic             m_err_f;
    logic [DW-1:0]    m_rdata_f;
    logic [NS-1:0]    s_sel_f;
    logic [31:0]      s_addr_f;
    logic             s_we_f;
    logic [DW-1:0]    s_wdata_f;
    logic [NS-1:0]    s_ack_f;
    logic [NS*DW-1:0] s_rdata_f;

    assign m_addr_f  = {32'hFFEF_3200, 32'hFFEF_2200, 32'hFFEF_1200, 32'hFFEF_0200};
    assign m_we_f    = '0;
    assign m_wdata_f = '0;
    assign s_ack_f   = s_sel_f;
    assign s_rdata_f = '0;

    arb_nxm #(.NUM_M(NM), .NUM_S(NS), .DATA_W(DW), .RR(1), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m_req(m_req), .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata),
        .m_gnt(m_gnt), .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata),
        .s_sel(s_sel), .s_addr(s_addr), .s_we(s_we), .s_wdata(s_wdata),
        .s_ack(s_ack), .s_rdata(s_rdata)
    );

    arb_nxm #(.NUM_M(NM), .NUM_S(NS), .DATA_W(DW), .RR(0), .TIMEOUT(TO)) dut_fixed (
        .clk(clk), .rst(rst),
        .m_req(m_req_f), .m_addr(m_addr_f), .m_we(m_we_f), .m_wdata(m_wdata_f),
        .m_gnt(m_gnt_f), .m_ack(m_ack_f), .m_err(m_err_f), .m_rdata(m_rdata_f),
        .s_sel(s_sel_f), .s_addr(s_addr_f), .s_we(s_we_f), .s_wdata(s_wdata_f),
        .s_ack(s_ack_f), .s_rdata(s_rdata_f)
    );

    int total = 0;
    int bad   = 0;
    int last  = NM - 1;

    function automatic logic [3:0] oh(input int i);
        oh = 4'b0001 << i;
    endfunction

    function automatic logic [127:0] pack(input logic [3:0] g, input logic [3:0] a, input logic e,
                                          input logic [31:0] rd, input logic [3:0] sel,
                                          input logic [31:0] ad, input logic we, input logic [31:0] wd);
        pack = {18'b0, g, a, e, rd, sel, ad, we, wd};
    endfunction

    function automatic logic [127:0] obs_main();
        obs_main = pack(m_gnt, m_ack, m_err, m_rdata, s_sel, s_addr, s_we, s_wdata);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction from an idle bus: the slave acks in transfer cycle 'delay' (never if delay > TO).
    task automatic applyStimulus(input logic [NM-1:0] mask, input int delay, input bit drop_early);
        int            w, sl, nxfer, idx;
        bit            hit, err, we;
        logic [NM-1:0] sh;
        logic [31:0]   a;
        logic [DW-1:0] wd, rd;

        step();
        checkOutput("idle", obs_main(), '0);
        m_req = mask;
        s_ack = '0;

        w = -1;
        for (int k = 1; k <= NM; k++) begin
            idx = (last + k) % NM;
            sh  = mask >> idx;
            if (w < 0 && sh[0]) w = idx;
        end
        last = w;

        a     = 32'(m_addr >> (32 * w));
        sh    = m_we >> w;
        we    = sh[0];
        wd    = DW'(m_wdata >> (DW * w));
        sl    = int'(a[15:12]);
        hit   = (a[31:16] == 16'hFFEF) && (a[11:8] == 4'h2) && (sl < NS);
        rd    = hit ? DW'(s_rdata >> (DW * sl)) : '0;
        nxfer = !hit ? 1 : ((delay <= TO) ? delay : TO);
        err   = !hit || (delay > TO);

        for (int c = 1; c <= nxfer; c++) begin
            step();
            s_ack = 4'($urandom);
            if (hit) s_ack = (s_ack & ~oh(sl)) | ((c == delay) ? oh(sl) : 4'b0);
            if (drop_early) m_req = m_req & ~oh(w);
            checkOutput("xfer", obs_main(),
                        pack(oh(w), 4'b0, 1'b0, 32'b0, hit ? oh(sl) : 4'b0,
                             hit ? a : 32'b0, hit ? we : 1'b0, hit ? wd : 32'b0));
        end

        step();
        s_ack = '0;
        checkOutput("resp", obs_main(),
                    pack(oh(w), oh(w), err, (!err && !we) ? rd : 32'b0, 4'b0, 32'b0, 1'b0, 32'b0));
        m_req = m_req & ~oh(w);
    endtask

    initial begin
        logic [NM-1:0] mask;
        int            kind, s;

        rst = 1'b1;
        m_req = '0; m_addr = '0; m_we = '0; m_wdata = '0;
        s_ack = '0; s_rdata = '0; m_req_f = '0;
        repeat (3) step();
        checkOutput("reset main", obs_main(), '0);
        checkOutput("reset fixed", {124'b0, m_gnt_f}, '0);
        rst = 1'b0;

        // Single read from slave 2, acked in the third transfer cycle.
        m_addr[63:32]  = 32'hFFEF_2204;
        s_rdata[95:64] = 32'hDEAD_BEEF;
        applyStimulus(4'b0010, 3, 1'b0);

        // Slave index beyond NUM_S decodes as a miss.
        m_addr[31:0] = 32'hFFEF_5200;
        applyStimulus(4'b0001, 1, 1'b0);

        // Slave never acks, then acks on the very last allowed cycle.
        m_addr[95:64] = 32'hFFEF_3210;
        applyStimulus(4'b0100, TO + 5, 1'b0);
        applyStimulus(4'b0100, TO, 1'b1);

        // All masters requesting with immediate acks rotate the grant.
        m_addr  = {32'hFFEF_3200, 32'hFFEF_2200, 32'hFFEF_1200, 32'hFFEF_0200};
        m_we    = 4'b0101;
        m_wdata = {$urandom, $urandom, $urandom, $urandom};
        s_rdata = {$urandom, $urandom, $urandom, $urandom};
        repeat (5) applyStimulus(4'b1111, 1, 1'b0);

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < NM; i++) begin
                kind = int'($urandom % 4);
                s    = int'($urandom % 4);
                case (kind)
                    0, 1:    m_addr[32*i +: 32] = {16'hFFEF, 4'(s), 4'h2, 8'($urandom)};
                    2:       m_addr[32*i +: 32] = {16'hFFEF, 4'(4 + $urandom % 12), 4'h2, 8'($urandom)};
                    default: m_addr[32*i +: 32] = {16'hFFEF, 4'(s), 4'h3, 8'($urandom)};
                endcase
            end
            m_we    = 4'($urandom);
            m_wdata = {$urandom, $urandom, $urandom, $urandom};
            s_rdata = {$urandom, $urandom, $urandom, $urandom};
            mask    = 4'($urandom_range(1, 15));
            applyStimulus(mask, 1 + int'($urandom % 12), 1'($urandom % 2));
        end
        m_req = '0;
        step();
        step();

        // Reset in the middle of a write aborts it without an ack and restores the RR pointer.
        step();
        m_addr[31:0]  = 32'hFFEF_1208;
        m_we          = 4'b0001;
        m_wdata[31:0] = 32'h1234_5678;
        m_req         = 4'b0001;
        s_ack         = '0;
        step();
        checkOutput("rst xfer c1", obs_main(),
                    pack(4'b0001, 4'b0, 1'b0, 32'b0, 4'b0010, 32'hFFEF_1208, 1'b1, 32'h1234_5678));
        step();
        checkOutput("rst xfer c2", obs_main(),
                    pack(4'b0001, 4'b0, 1'b0, 32'b0, 4'b0010, 32'hFFEF_1208, 1'b1, 32'h1234_5678));
        rst = 1'b1;
        step();
        checkOutput("rst c3", obs_main(), '0);
        rst   = 1'b0;
        m_req = '0;
        step();
        checkOutput("rst c4", obs_main(), '0);
        last          = NM - 1;
        m_addr[31:0]  = 32'hFFEF_0200;
        m_addr[127:96] = 32'hFFEF_3200;
        m_we          = '0;
        applyStimulus(4'b1001, 2, 1'b0);
        m_req = '0;
        step();

        // Fixed priority: the lowest-index requester wins every time.
        step();
        m_req_f = 4'b1111;
        for (int c = 1; c <= 9; c++) begin
            step();
            checkOutput("fixed gnt all", {124'b0, m_gnt_f}, {124'b0, (c % 3 != 0) ? 4'b0001 : 4'b0000});
        end
        m_req_f = 4'b1010;
        for (int c = 1; c <= 6; c++) begin
            step();
            checkOutput("fixed gnt 1010", {124'b0, m_gnt_f}, {124'b0, (c % 3 != 0) ? 4'b0010 : 4'b0000});
        end
        m_req_f = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
